multi_cycle_sequencer: RTL and testbench

Sequencing FSM that drives the core datapath one instruction at a time: fetch, decode, execute, memory, writeback. It consumes the control flags produced by the instruction decoder. It gates every architectural write (PC, IR, register file, data/instruction memory). It performs start/done and req/ack handshakes with the multi-cycle FPU and the data memory, and provides a wait timeout plus retire and cycle counters.

---
 rtl/multi_cycle_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_multi_cycle_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// multi_cycle_sequencer
//
// Steps the core datapath through one instruction at a time:
// FETCH -> DECODE -> EXEC -> (MEM) -> WB -> FETCH.
// Architectural write enables (PC, IR, register file, data/instruction memory)
// are only raised by this block. It also runs the start/done handshake with the
// multi-cycle FPU and the req/ack handshake with memory. If either handshake
// waits too long, the sequencer parks in HALT with a sticky fault flag.
// A free-running cycle counter and a retired-instruction counter are kept too.
//
// Parameters
//   TIMEOUT    maximum wait cycles in an FPU or memory handshake (>= 2)
//
// Ports
//   clk          in   core clock
//   rst          in   synchronous active-high reset
//   fetch_stall  in   hold in FETCH (program loader / debugger)
//   memread      in   decoder flag: load
//   memwrite     in   decoder flag: store
//   imemwrite    in   decoder flag: instruction-memory write
//   regwrite     in   decoder flag: write register file in WB
//   aluorfpu     in   decoder flag: 1 = result comes from the FPU
//   fpu_done     in   FPU result valid pulse
//   mem_ack      in   memory access complete
//   imem_en      out  instruction-memory read enable
//   ir_we        out  latch instruction register
//   fpu_start    out  FPU start pulse
//   mem_req      out  memory request, held until ack
//   mem_we       out  data-memory write strobe (qualified by mem_req)
//   imem_we      out  instruction-memory write strobe (qualified by mem_req)
//   rf_we        out  register-file write enable
//   pc_we        out  PC update enable
//   fault        out  sticky handshake-timeout flag
//   instret      out  retired-instruction count
//   cycles       out  cycle count since reset
// -----------------------------------------------------------------------------
module multi_cycle_sequencer #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_stall,
   input  logic        memread,
   input  logic        memwrite,
   input  logic        imemwrite,
   input  logic        regwrite,
   input  logic        aluorfpu,
   input  logic        fpu_done,
   input  logic        mem_ack,
   output logic        imem_en,
   output logic        ir_we,
   output logic        fpu_start,
   output logic        mem_req,
   output logic        mem_we,
   output logic        imem_we,
   output logic        rf_we,
   output logic        pc_we,
   output logic        fault,
   output logic [31:0] instret,
   output logic [31:0] cycles
);

   // The wait counter must be able to hold TIMEOUT itself.
   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t            state_q,     state_d;
   logic [WAIT_W-1:0] wait_q,      wait_d;
   logic              memwrite_q,  memwrite_d;
   logic              imemwrite_q, imemwrite_d;
   logic              regwrite_q,  regwrite_d;
   logic [31:0]       instret_q,   instret_d;
   logic [31:0]       cycles_q,    cycles_d;

   // State and counter registers. Reset is synchronous and wins from any
   // state, including the middle of a handshake, so an outstanding mem_req
   // is dropped on the reset edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_FETCH;
         wait_q      <= '0;
         memwrite_q  <= 1'b0;
         imemwrite_q <= 1'b0;
         regwrite_q  <= 1'b0;
         instret_q   <= '0;
         cycles_q    <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         memwrite_q  <= memwrite_d;
         imemwrite_q <= imemwrite_d;
         regwrite_q  <= regwrite_d;
         instret_q   <= instret_d;
         cycles_q    <= cycles_d;
      end
   end

   // Next-state logic. The wait counter is loaded with 1 on entry to EXEC
   // and MEM so that it equals the number of the current wait cycle; when it
   // reaches TIMEOUT with no done/ack we head for HALT on the next edge.
   // The write-type decoder flags are captured while in EXEC so that the MEM
   // and WB strobes come purely from registers and stay constant.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      memwrite_d  = memwrite_q;
      imemwrite_d = imemwrite_q;
      regwrite_d  = regwrite_q;
      instret_d   = instret_q;
      cycles_d    = cycles_q + 32'd1;

      case (state_q)
         S_FETCH: begin
            if (!fetch_stall) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = S_EXEC;
            wait_d  = WAIT_ONE;
         end
         S_EXEC: begin
            memwrite_d  = memwrite;
            imemwrite_d = imemwrite;
            regwrite_d  = regwrite;
            if (!aluorfpu) begin
               if (memread || memwrite || imemwrite) begin
                  state_d = S_MEM;
                  wait_d  = WAIT_ONE;
               end else begin
                  state_d = S_WB;
               end
            end else if (fpu_done && (wait_q != WAIT_ONE)) begin
               // A done pulse in the start cycle belongs to nothing we issued.
               state_d = S_WB;
            end else if (wait_q == WAIT_MAX) begin
               state_d = S_HALT;
            end else begin
               wait_d = wait_q + WAIT_ONE;
            end
         end
         S_MEM: begin
            if (mem_ack) begin
               state_d = S_WB;
            end else if (wait_q == WAIT_MAX) begin
               state_d = S_HALT;
            end else begin
               wait_d = wait_q + WAIT_ONE;
            end
         end
         S_WB: begin
            state_d   = S_FETCH;
            instret_d = instret_q + 32'd1;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Output decode from the registered state. Each state owns at most one of
   // ir_we / fpu_start / mem_req / pc_we, which keeps those strobes mutually
   // exclusive. fpu_start also looks at aluorfpu: the decoder flags come from
   // the IR latched in DECODE, so they are already stable in the first EXEC
   // cycle and this is the only way to start the FPU without losing a cycle.
   always_comb begin
      imem_en   = 1'b0;
      ir_we     = 1'b0;
      fpu_start = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      imem_we   = 1'b0;
      rf_we     = 1'b0;
      pc_we     = 1'b0;

      case (state_q)
         S_FETCH: begin
            imem_en = !fetch_stall;
         end
         S_DECODE: begin
            ir_we = 1'b1;
         end
         S_EXEC: begin
            fpu_start = aluorfpu && (wait_q == WAIT_ONE);
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = memwrite_q;
            imem_we = imemwrite_q;
         end
         S_WB: begin
            rf_we = regwrite_q;
            pc_we = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // HALT is only left through reset, so being in HALT is the sticky fault.
   assign fault   = (state_q == S_HALT);
   assign instret = instret_q;
   assign cycles  = cycles_q;

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_sequencer
//
// Directed bench for multi_cycle_sequencer. Two instances share all inputs:
// one with a generous TIMEOUT for normal instruction flows, one with
// TIMEOUT=4 for the handshake-timeout scenario. The stimulus process pushes
// the expected strobe events (with their cycle stamps) into a queue; a monitor
// pops and compares whenever the selected instance raises a strobe.
// -----------------------------------------------------------------------------
module tb_multi_cycle_sequencer;

   typedef struct packed {
      logic        imem_en;
      logic        ir_we;
      logic        fpu_start;
      logic        mem_req;
      logic        mem_we;
      logic        imem_we;
      logic        rf_we;
      logic        pc_we;
      logic        fault;
      logic [31:0] instret;
      logic [31:0] cycles;
   } obs_t;

   typedef struct packed {
      logic        ir_we;
      logic        fpu_start;
      logic        mem_req;
      logic        mem_we;
      logic        imem_we;
      logic        rf_we;
      logic        pc_we;
      logic [31:0] instret;
      logic [31:0] cycles;
   } exp_t;

   logic clk;
   logic rst;
   logic fetch_stall;
   logic memread;
   logic memwrite;
   logic imemwrite;
   logic regwrite;
   logic aluorfpu;
   logic fpu_done;
   logic mem_ack;
   logic sel_to;

   logic        a_imem_en, a_ir_we, a_fpu_start, a_mem_req, a_mem_we;
   logic        a_imem_we, a_rf_we, a_pc_we, a_fault;
   logic [31:0] a_instret, a_cycles;
   logic        b_imem_en, b_ir_we, b_fpu_start, b_mem_req, b_mem_we;
   logic        b_imem_we, b_rf_we, b_pc_we, b_fault;
   logic [31:0] b_instret, b_cycles;

   obs_t obs_a;
   obs_t obs_b;
   obs_t obs;

   exp_t sb_q[$];
   int   total;
   int   bad;

   multi_cycle_sequencer #(.TIMEOUT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_stall (fetch_stall),
      .memread     (memread),
      .memwrite    (memwrite),
      .imemwrite   (imemwrite),
      .regwrite    (regwrite),
      .aluorfpu    (aluorfpu),
      .fpu_done    (fpu_done),
      .mem_ack     (mem_ack),
      .imem_en     (a_imem_en),
      .ir_we       (a_ir_we),
      .fpu_start   (a_fpu_start),
      .mem_req     (a_mem_req),
      .mem_we      (a_mem_we),
      .imem_we     (a_imem_we),
      .rf_we       (a_rf_we),
      .pc_we       (a_pc_we),
      .fault       (a_fault),
      .instret     (a_instret),
      .cycles      (a_cycles)
   );

   multi_cycle_sequencer #(.TIMEOUT(4)) dut_to (
      .clk         (clk),
      .rst         (rst),
      .fetch_stall (fetch_stall),
      .memread     (memread),
      .memwrite    (memwrite),
      .imemwrite   (imemwrite),
      .regwrite    (regwrite),
      .aluorfpu    (aluorfpu),
      .fpu_done    (fpu_done),
      .mem_ack     (mem_ack),
      .imem_en     (b_imem_en),
      .ir_we       (b_ir_we),
      .fpu_start   (b_fpu_start),
      .mem_req     (b_mem_req),
      .mem_we      (b_mem_we),
      .imem_we     (b_imem_we),
      .rf_we       (b_rf_we),
      .pc_we       (b_pc_we),
      .fault       (b_fault),
      .instret     (b_instret),
      .cycles      (b_cycles)
   );

   // Bundle each instance's outputs and pick the one under observation.
   assign obs_a = '{a_imem_en, a_ir_we, a_fpu_start, a_mem_req, a_mem_we,
                    a_imem_we, a_rf_we, a_pc_we, a_fault, a_instret, a_cycles};
   assign obs_b = '{b_imem_en, b_ir_we, b_fpu_start, b_mem_req, b_mem_we,
                    b_imem_we, b_rf_we, b_pc_we, b_fault, b_instret, b_cycles};
   assign obs   = sel_to ? obs_b : obs_a;

   // 10 ns core clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something wedges the stimulus process.
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: time limit reached, summary not reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic exp_t mk(input logic ir, input logic fs, input logic mr,
                               input logic mw, input logic iw, input logic rf,
                               input logic pc, input logic [31:0] ic,
                               input logic [31:0] cyc);
      exp_t e;
      e = '{ir, fs, mr, mw, iw, rf, pc, ic, cyc};
      return e;
   endfunction

   // Expected-event helpers; cyc is the value of 'cycles' during the event.
   task automatic push_ir(input int cyc, input int ic);
      sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'(ic), 32'(cyc)));
   endtask

   task automatic push_fs(input int cyc, input int ic);
      sb_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'(ic), 32'(cyc)));
   endtask

   task automatic push_mem(input logic mw, input logic iw, input int cyc, input int ic);
      sb_q.push_back(mk(1'b0, 1'b0, 1'b1, mw, iw, 1'b0, 1'b0, 32'(ic), 32'(cyc)));
   endtask

   task automatic push_wb(input logic rf, input int cyc, input int ic);
      sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rf, 1'b1, 32'(ic), 32'(cyc)));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic applyStimulus(input logic stall, input logic mr, input logic mw,
                                input logic iw, input logic rw, input logic aof);
      fetch_stall = stall;
      memread     = mr;
      memwrite    = mw;
      imemwrite   = iw;
      regwrite    = rw;
      aluorfpu    = aof;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, need %0d", name, actual, expected);
      end
   endtask

   // Scoreboard monitor: every cycle in which the observed instance raises a
   // strobe is matched against the oldest expected event.
   always @(negedge clk) begin : monitor
      exp_t act;
      exp_t want;
      if (obs.ir_we | obs.fpu_start | obs.mem_req | obs.rf_we | obs.pc_we) begin
         act = mk(obs.ir_we, obs.fpu_start, obs.mem_req, obs.mem_we, obs.imem_we,
                  obs.rf_we, obs.pc_we, obs.instret, obs.cycles);
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL sb_unexpected: got ir=%0b fs=%0b mr=%0b mw=%0b iw=%0b rf=%0b pc=%0b cycles=%0d, need no strobe",
                     act.ir_we, act.fpu_start, act.mem_req, act.mem_we, act.imem_we,
                     act.rf_we, act.pc_we, act.cycles);
         end else begin
            want = sb_q.pop_front();
            if (act !== want) begin
               bad++;
               $display("[TB] FAIL sb_event: got ir=%0b fs=%0b mr=%0b mw=%0b iw=%0b rf=%0b pc=%0b instret=%0d cycles=%0d, need ir=%0b fs=%0b mr=%0b mw=%0b iw=%0b rf=%0b pc=%0b instret=%0d cycles=%0d",
                        act.ir_we, act.fpu_start, act.mem_req, act.mem_we, act.imem_we,
                        act.rf_we, act.pc_we, act.instret, act.cycles,
                        want.ir_we, want.fpu_start, want.mem_req, want.mem_we, want.imem_we,
                        want.rf_we, want.pc_we, want.instret, want.cycles);
            end
         end
      end
   end

   // Directed scenarios. Each one resets, queues its expected strobe events,
   // drives the handshake inputs at fixed cycles, then parks the sequencer in
   // FETCH with fetch_stall and checks the counters directly.
   initial begin
      total  = 0;
      bad    = 0;
      sel_to = 1'b0;
      rst    = 1'b1;
      fpu_done = 1'b0;
      mem_ack  = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;

      // Reset state with fetch held: every output low, counters zero.
      @(negedge clk);
      checkOutput("reset_strobes", 32'({obs.imem_en, obs.ir_we, obs.fpu_start, obs.mem_req,
                                        obs.mem_we, obs.imem_we, obs.rf_we, obs.pc_we}), 32'd0);
      checkOutput("reset_fault", 32'(obs.fault), 32'd0);
      checkOutput("reset_instret", obs.instret, 32'd0);
      checkOutput("reset_cycles", obs.cycles, 32'd0);

      // ALU op; stray done/ack outside their wait states must be ignored.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      fpu_done = 1'b1;
      mem_ack  = 1'b1;
      push_ir(1, 0);
      push_wb(1'b1, 3, 0);
      doReset();
      @(negedge clk);
      checkOutput("alu_imem_en", 32'(obs.imem_en), 32'd1);
      repeat (4) tick();
      fetch_stall = 1'b1;
      fpu_done = 1'b0;
      mem_ack  = 1'b0;
      @(negedge clk);
      checkOutput("alu_instret", obs.instret, 32'd1);
      checkOutput("alu_cycles", obs.cycles, 32'd4);

      // Load with ack in the 4th MEM cycle.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      push_ir(1, 0);
      for (int c = 3; c <= 6; c++) push_mem(1'b0, 1'b0, c, 0);
      push_wb(1'b1, 7, 0);
      doReset();
      repeat (6) tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      fetch_stall = 1'b1;
      @(negedge clk);
      checkOutput("load_instret", obs.instret, 32'd1);
      checkOutput("load_cycles", obs.cycles, 32'd8);

      // FPU op: done in the start cycle (ignored) and again 5 cycles later.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      push_ir(1, 0);
      push_fs(2, 0);
      push_wb(1'b1, 8, 0);
      doReset();
      repeat (2) tick();
      fpu_done = 1'b1;
      tick();
      fpu_done = 1'b0;
      repeat (4) tick();
      fpu_done = 1'b1;
      tick();
      fpu_done = 1'b0;
      tick();
      fetch_stall = 1'b1;
      @(negedge clk);
      checkOutput("fpu_instret", obs.instret, 32'd1);
      checkOutput("fpu_cycles", obs.cycles, 32'd9);

      // Store then swi back to back, ack tied high.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      mem_ack = 1'b1;
      push_ir(1, 0);
      push_mem(1'b1, 1'b0, 3, 0);
      push_wb(1'b0, 4, 0);
      push_ir(6, 1);
      push_mem(1'b0, 1'b1, 8, 1);
      push_wb(1'b0, 9, 1);
      doReset();
      repeat (5) tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (5) tick();
      fetch_stall = 1'b1;
      mem_ack = 1'b0;
      @(negedge clk);
      checkOutput("st_swi_instret", obs.instret, 32'd2);
      checkOutput("st_swi_cycles", obs.cycles, 32'd10);

      // Fetch stall for 10 cycles after reset, then one ALU op.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push_ir(11, 0);
      push_wb(1'b0, 13, 0);
      doReset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("stall_imem_en", 32'(obs.imem_en), 32'd0);
         tick();
      end
      fetch_stall = 1'b0;
      @(negedge clk);
      checkOutput("release_cycles", obs.cycles, 32'd10);
      checkOutput("release_imem_en", 32'(obs.imem_en), 32'd1);
      repeat (4) tick();
      fetch_stall = 1'b1;
      @(negedge clk);
      checkOutput("stall_instret", obs.instret, 32'd1);
      checkOutput("stall_cycles", obs.cycles, 32'd14);

      // Reset asserted in the second MEM cycle: mem_req drops on the edge.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      push_ir(1, 0);
      push_mem(1'b0, 1'b0, 3, 0);
      push_mem(1'b0, 1'b0, 4, 0);
      doReset();
      repeat (4) tick();
      rst = 1'b1;
      fetch_stall = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midmem_req", 32'(obs.mem_req), 32'd0);
      checkOutput("midmem_cycles", obs.cycles, 32'd0);

      // Timeout on the TIMEOUT=4 instance: load with ack stuck low.
      sel_to = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      mem_ack = 1'b0;
      push_ir(1, 0);
      for (int c = 3; c <= 6; c++) push_mem(1'b0, 1'b0, c, 0);
      doReset();
      repeat (6) tick();
      @(negedge clk);
      checkOutput("to_fault_before", 32'(obs.fault), 32'd0);
      tick();
      @(negedge clk);
      checkOutput("to_fault", 32'(obs.fault), 32'd1);
      checkOutput("to_strobes", 32'({obs.imem_en, obs.ir_we, obs.fpu_start, obs.mem_req,
                                     obs.mem_we, obs.imem_we, obs.rf_we, obs.pc_we}), 32'd0);
      checkOutput("to_instret", obs.instret, 32'd0);
      mem_ack = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      checkOutput("halt_fault", 32'(obs.fault), 32'd1);
      checkOutput("halt_cycles", obs.cycles, 32'd11);
      checkOutput("halt_instret", obs.instret, 32'd0);
      checkOutput("halt_strobes", 32'({obs.imem_en, obs.ir_we, obs.fpu_start, obs.mem_req,
                                       obs.mem_we, obs.imem_we, obs.rf_we, obs.pc_we}), 32'd0);
      mem_ack = 1'b0;

      // Reset out of HALT and retire an ALU op on the same instance.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      push_ir(1, 0);
      push_wb(1'b1, 3, 0);
      doReset();
      @(negedge clk);
      checkOutput("rst_halt_fault", 32'(obs.fault), 32'd0);
      checkOutput("rst_halt_cycles", obs.cycles, 32'd0);
      repeat (4) tick();
      fetch_stall = 1'b1;
      @(negedge clk);
      checkOutput("rst_halt_instret", obs.instret, 32'd1);

      tick();
      tick();
      checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
